// File: rtl/video_timing_pkg.sv
// Shared timing constants and scan-state encoding for the display timing path.
// Defaults describe 1280x720 with the standard CEA porch and sync widths.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned H_FP_720P     = 110;
    localparam int unsigned H_SYNC_720P   = 40;
    localparam int unsigned H_BP_720P     = 220;
    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned V_FP_720P     = 5;
    localparam int unsigned V_SYNC_720P   = 5;
    localparam int unsigned V_BP_720P     = 20;

    localparam int unsigned H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
    localparam int unsigned V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

    // Sync windows are half-open: [BEG, END)
    localparam int unsigned HS_BEG_720P = H_ACTIVE_720P + H_FP_720P;
    localparam int unsigned HS_END_720P = HS_BEG_720P + H_SYNC_720P;
    localparam int unsigned VS_BEG_720P = V_ACTIVE_720P + V_FP_720P;
    localparam int unsigned VS_END_720P = VS_BEG_720P + V_SYNC_720P;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/video_timing_wrap_counter.sv
// Modulo counter: advances on en, returns to 0 after TERM or on clear.
// count_next exposes the value being loaded so callers can register decodes aligned with count.
module wrap_counter #(
    parameter int unsigned W    = 12,
    parameter int unsigned TERM = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TERM);

    // Terminal compare comes before the increment, so count never overflows.
    assign wrap = en && (count == LAST);

    always_comb begin
        count_next = count;
        if (clear || wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_controller.sv
// Horizontal/vertical scan sequencer with frame-boundary start/stop control.
// Sync and active decodes are registered from next-state counts so they line up with hcount/vcount.
import video_timing_pkg::*;

module video_timing_controller #(
    parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
    parameter int unsigned H_FP     = H_FP_720P,
    parameter int unsigned H_SYNC   = H_SYNC_720P,
    parameter int unsigned H_BP     = H_BP_720P,
    parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
    parameter int unsigned V_FP     = V_FP_720P,
    parameter int unsigned V_SYNC   = V_SYNC_720P,
    parameter int unsigned V_BP     = V_BP_720P,
    parameter int unsigned SYNC_POL = 1,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             POL     = (SYNC_POL != 0);

    state_t           state_q, state_d;
    logic             scan, scan_d;
    logic             h_en, h_wrap, v_wrap;
    logic [CNT_W-1:0] h_next, v_next;

    assign scan   = (state_q != IDLE);
    assign scan_d = (state_d != IDLE);
    assign h_en   = en && scan;

    wrap_counter #(
        .W    (CNT_W),
        .TERM (H_TOTAL - 1)
    ) u_hcnt (
        .clk        (clk),
        .rst        (rst),
        .en         (h_en),
        .clear      (!scan),
        .count      (hcount),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(
        .W    (CNT_W),
        .TERM (V_TOTAL - 1)
    ) u_vcnt (
        .clk        (clk),
        .rst        (rst),
        .en         (h_wrap && h_en),
        .clear      (!scan),
        .count      (vcount),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // v_wrap is only ever high on an en edge at the last pixel of the frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop) state_d = DRAIN;
            DRAIN: begin
                if (start && !stop) begin
                    state_d = RUN;
                end else if (v_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            running <= 1'b0;
            active  <= 1'b0;
            hsync   <= ~POL;
            vsync   <= ~POL;
        end else begin
            state_q <= state_d;
            running <= scan_d;
            active  <= scan_d && (h_next < H_ACT_C) && (v_next < V_ACT_C);
            hsync   <= (scan_d && (h_next >= HS_BEG) && (h_next < HS_END)) ? POL : ~POL;
            vsync   <= (scan_d && (v_next >= VS_BEG) && (v_next < VS_END)) ? POL : ~POL;
        end
    end

    assign line_start  = en && running && (hcount == '0);
    assign frame_start = line_start && (vcount == '0);

endmodule

// File: tb/tb_video_timing_controller.sv
// Scoreboard bench for video_timing_controller on reduced timing (H 8/2/2/2, V 4/1/1/1).
// Expected values come from a behavioural scan model and a hand-written vector table.
module tb_video_timing_controller;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst, en, start, stop;
    logic [11:0] hcount, vcount;
    logic        hsync, vsync, active, line_start, frame_start, running;

    always #5 clk = ~clk;

    video_timing_controller #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1), .CNT_W (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .stop        (stop),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
    );

    typedef struct {
        logic [11:0] h, v;
        logic        hs, vs, act, run;
    } exp_t;

    typedef struct {
        logic        r, e, s, p;
        logic [11:0] h, v;
        logic        hs, vs, act, run, ls, fs;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_state, m_h, m_v;   // 0 idle, 1 run, 2 drain
    int   cyc = 0;
    logic fs_now, ls_now;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, a, e, $time);
        end
    endtask

    task automatic model_advance(input logic r, input logic e, input logic s, input logic p);
        logic last;
        last = e && (m_h == HT - 1) && (m_v == VT - 1);
        if (!r) begin
            m_state = 0; m_h = 0; m_v = 0;
        end else begin
            if (m_state != 0 && e) begin
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            case (m_state)
                0: if (s && !p) m_state = 1;
                1: if (p) m_state = 2;
                default: begin
                    if (s && !p) m_state = 1;
                    else if (last) m_state = 0;
                end
            endcase
        end
    endtask

    function automatic exp_t model_exp();
        exp_t x;
        logic run;
        run   = (m_state != 0);
        x.h   = 12'(m_h);
        x.v   = 12'(m_v);
        x.run = run;
        x.act = run && m_h < 8 && m_v < 4;
        x.hs  = run && m_h >= 10 && m_h < 12;
        x.vs  = run && m_v == 5;
        return x;
    endfunction

    task automatic cycle(input logic r, input logic e, input logic s, input logic p,
                         input exp_t ex, input logic ls, input logic fs);
        exp_t got;
        rst = r; en = e; start = s; stop = p;
        #3;
        ls_now = line_start;
        fs_now = frame_start;
        chk("line_start", line_start, ls);
        chk("frame_start", frame_start, fs);
        sbq.push_back(ex);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        chk("hcount", hcount, got.h);
        chk("vcount", vcount, got.v);
        chk("hsync", hsync, got.hs);
        chk("vsync", vsync, got.vs);
        chk("active", active, got.act);
        chk("running", running, got.run);
        cyc++;
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic p);
        logic ls, fs;
        ls = e && (m_state != 0) && (m_h == 0);
        fs = ls && (m_v == 0);
        model_advance(r, e, s, p);
        cycle(r, e, s, p, model_exp(), ls, fs);
    endtask

    // Run n cycles with en once every `every` cycles and measure frame/line periods from the DUT.
    task automatic run_measure(input int n, input int every);
        int last_fs = -1, last_ls = -1, act_cnt = 0, vs_cnt = 0;
        logic armed = 1'b0;
        for (int k = 0; k < n; k++) begin
            step(1'b1, (k % every) == 0, 1'b0, 1'b0);
            if (ls_now) begin
                if (last_ls >= 0) chk("line_period", cyc - last_ls, HT * every);
                last_ls = cyc;
            end
            if (fs_now) begin
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME * every);
                if (armed) begin
                    chk("active_per_frame", act_cnt, 32 * every);
                    chk("vsync_per_frame", vs_cnt, HT * every);
                end
                last_fs = cyc; armed = 1'b1; act_cnt = 0; vs_cnt = 0;
            end
            if (armed) begin
                act_cnt += int'(active);
                vs_cnt  += int'(vsync);
            end
        end
    endtask

    task automatic run_until(input int h, input int v, input string name);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < 4 * FRAME) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= 4 * FRAME) chk({name, "_timeout"}, n, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[17];
        int   cnt, n;

        //          r     e     s     p     h  v  hs    vs    act   run   ls    fs
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1;
        m_state = 0; m_h = 0; m_v = 0;

        for (int i = 0; i < 17; i++) begin
            exp_t ex;
            ex.h = vt[i].h; ex.v = vt[i].v; ex.hs = vt[i].hs; ex.vs = vt[i].vs;
            ex.act = vt[i].act; ex.run = vt[i].run;
            model_advance(vt[i].r, vt[i].e, vt[i].s, vt[i].p);
            cycle(vt[i].r, vt[i].e, vt[i].s, vt[i].p, ex, vt[i].ls, vt[i].fs);
        end

        // Continuous and throttled scanning.
        run_measure(3 * FRAME, 1);
        run_measure(3 * FRAME * 4, 4);

        // Graceful stop mid-frame, then idle with no further frame_start.
        run_until(0, 3, "reach_stop_line");
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (m_state != 0 && n < 2 * FRAME) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("drain_cycles", n, FRAME - HT * 3 - 1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            cnt += int'(frame_start) + int'(running);
        end
        chk("idle_after_stop", cnt, 0);

        // Stop cancelled by start during drain: no gap in scanning.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_until(0, 2, "reach_stop2");
        step(1'b1, 1'b1, 1'b0, 1'b1);
        run_until(0, 5, "reach_cancel");
        step(1'b1, 1'b1, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            cnt += int'(!running);
        end
        chk("no_gap_after_cancel", cnt, 0);

        // Reset mid-frame, then restart from (0,0).
        run_until(7, 2, "reach_reset_pt");
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        run_measure(2 * FRAME, 1);

        // Random control traffic.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_controller.md
Name: video_timing_controller

Overview:
- Sequences the horizontal and vertical pixel counters of the 1280x720 display path.
- Starts and stops the scan cleanly at frame boundaries.
- Decodes hsync, vsync and active-video from the counts.
- Sits between the pixel-clock enable source and the pixel/colour generation logic. All display timing in the design derives from this block.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)
- CNT_W, 12, counter width; must satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk)
- en  in  1  pixel tick; counters advance only on clk edges with en=1
- start  in  1  level/pulse request to begin scanning
- stop  in  1  level/pulse request to stop after the current frame
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  1 when the current pixel is visible
- line_start  out  1  1 while en=1 and hcount=0 (scanning only)
- frame_start  out  1  1 while en=1 and hcount=0 and vcount=0 (scanning only)
- running  out  1  1 in RUN or DRAIN

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Reset (rst=0 at clk edge):
  - state=IDLE, hcount=0, vcount=0
  - hsync=vsync=~SYNC_POL, active=0, running=0
  - Applies mid-frame with no exceptions.
- States:
  - IDLE: counters held at 0, outputs at their reset values.
    - start=1 and stop=0 -> RUN on the next edge.
    - start=1 and stop=1 -> stay in IDLE (stop has priority).
  - RUN: counters advance on en.
    - stop=1 -> DRAIN, regardless of start.
  - DRAIN: counters keep advancing.
    - start=1 and stop=0 -> RUN (cancels the stop).
    - en=1 at hcount=H_TOTAL-1, vcount=V_TOTAL-1 -> IDLE; counters go to 0 on that same edge.
- Counting (RUN/DRAIN, en=1):
  - hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - vcount increments only when hcount wraps, and wraps to 0 after V_TOTAL-1.
  - en=0: all registers hold.
- Decode, registered and aligned with hcount/vcount (compute from next-state counts):
  - active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1390..1429); otherwise ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (725..729), for the entire line; otherwise ~SYNC_POL.
  - In IDLE, sync outputs are inactive and active=0.
- line_start and frame_start:
  - Combinational AND of en, running and the registered count compare.
  - These are the only combinational outputs.
  - Exactly one clk cycle high per line/frame when en is a single-cycle tick.
- Latency: first en after entering RUN presents (0,0) with frame_start=1. hcount reaches 1 on the following en.
- No arithmetic overflow: the compare to TOTAL-1 precedes the increment. Unsigned compares at CNT_W.

Decomposition:
- Package video_timing_pkg holds:
  - 720p default constants and derived H_TOTAL/V_TOTAL
  - state enum {IDLE, RUN, DRAIN}
  - sync-window bound constants
- One sub-module, wrap_counter: parameterised width and terminal value; ports en, clear, count, wrap.
  - Instantiated twice. The vertical instance's en is the horizontal wrap ANDed with en.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> hcount=vcount=0, hsync=vsync=0, active=0, running=0.
- Full frame: start pulse, en=1 every cycle.
  - frame_start period = 1,237,500 cycles; line_start period = 1650.
  - hsync high for hcount 1390..1429 (40 cycles/line); vsync high for lines 725..729 (8250 cycles).
  - active count = 921,600 per frame.
- Throttled enable: en=1 on one cycle in 4 -> counts and syncs identical per tick; all registers hold on en=0 cycles; frame period = 4,950,000 cycles.
- Graceful stop: stop pulse at vcount=300.
  - Frame completes; IDLE entered on the edge at (1649,749); running drops.
  - No frame_start afterwards.
  - start during DRAIN at vcount=500 -> scanning continues without a gap.
- Reset mid-frame at (700,400) -> next edge gives IDLE with all reset values; start -> new frame from (0,0).
- Simultaneous start+stop:
  - In IDLE -> stays IDLE.
  - In RUN -> DRAIN.
- Reduced parameters (H 8/2/2/2, V 4/1/1/1) for exhaustive wrap checks.
